// File: rtl/sd_image_responder.sv
// HPS stand-in for the MiSTer SD block protocol. It pulses img_mounted on request and
// serves 512-byte sector reads/writes against a byte-wide image memory owned by the harness.
module sd_image_responder #(
  parameter int unsigned NUM_DRIVES = 1,
  parameter int unsigned IMG_AW     = 20,
  parameter int unsigned ACK_DELAY  = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic [NUM_DRIVES-1:0]    mount_req,
  input  logic [63:0]              mount_size,
  input  logic                     mount_ro,
  output logic [9:0]               img_mounted,
  output logic [63:0]              img_size,
  output logic                     img_readonly,
  input  logic [NUM_DRIVES*32-1:0] sd_lba,
  input  logic [9:0]               sd_rd,
  input  logic [9:0]               sd_wr,
  output logic [9:0]               sd_ack,
  output logic [8:0]               sd_buff_addr,
  output logic [7:0]               sd_buff_dout,
  output logic                     sd_buff_wr,
  input  logic [NUM_DRIVES*8-1:0]  sd_buff_din,
  output logic [IMG_AW-1:0]        mem_addr,
  output logic                     mem_rd,
  input  logic [7:0]               mem_dout,
  output logic                     mem_wr,
  output logic [7:0]               mem_din,
  output logic                     xfer_err
);

  localparam int unsigned DRV_W  = 4;
  localparam int unsigned NACK   = 10;
  localparam int unsigned CNT_W  = $clog2(ACK_DELAY + 1);
  localparam int unsigned BASE_W = 41;
  localparam int unsigned K_W    = 9;
  localparam logic [K_W-1:0] K_LAST = K_W'(511);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK_WAIT,
    S_RD_FETCH,
    S_RD_PUT,
    S_WR_ADDR,
    S_WR_CAP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [DRV_W-1:0]    drv_q, drv_d;
  logic                is_wr_q, is_wr_d;
  logic [BASE_W-1:0]   base_q, base_d;
  logic [K_W-1:0]      k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mute_q, mute_d;
  logic                err_set;

  logic [NACK-1:0]     ack_d;
  logic [K_W-1:0]      buff_addr_d;
  logic                buff_wr_d;
  logic                mem_rd_d;
  logic                mem_wr_d;
  logic [IMG_AW-1:0]   mem_addr_d;
  logic                active;

  logic                req_any;
  logic                pick_rd;
  logic [DRV_W-1:0]    pick;
  logic [31:0]         pick_lba;
  logic                held;
  logic [7:0]          din_sel;

  // Request lines of drives beyond NUM_DRIVES are never served.
  logic unused_req;
  assign unused_req = ^{sd_rd, sd_wr};

  // Lowest-index requester wins; read beats write within that drive.
  always_comb begin
    req_any  = 1'b0;
    pick     = '0;
    pick_rd  = 1'b0;
    pick_lba = '0;
    held     = 1'b0;
    din_sel  = '0;
    for (int i = NUM_DRIVES - 1; i >= 0; i--) begin
      if (sd_rd[i] || sd_wr[i]) begin
        req_any  = 1'b1;
        pick     = DRV_W'(i);
        pick_rd  = sd_rd[i];
        pick_lba = sd_lba[i*32 +: 32];
      end
    end
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (drv_q == DRV_W'(i)) begin
        held    = sd_rd[i] || sd_wr[i];
        din_sel = sd_buff_din[i*8 +: 8];
      end
    end
  end

  // Next state, plus the registered outputs decoded from the state being entered.
  always_comb begin
    state_d     = state_q;
    drv_d       = drv_q;
    is_wr_d     = is_wr_q;
    base_d      = base_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    mute_d      = mute_q;
    err_set     = 1'b0;
    ack_d       = '0;
    buff_addr_d = '0;
    buff_wr_d   = 1'b0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    mem_addr_d  = '0;
    active      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d = S_ACK_WAIT;
          drv_d   = pick;
          is_wr_d = !pick_rd;
          base_d  = {pick_lba, 9'd0};
          cnt_d   = '0;
        end
      end
      S_ACK_WAIT: begin
        if (cnt_q == CNT_W'(ACK_DELAY)) begin
          // Range is judged against the size current at ack time, so a remount during the wait counts.
          k_d     = '0;
          mute_d  = ((64'(base_q) + 64'd512) > img_size) || (is_wr_q && img_readonly);
          err_set = mute_d;
          state_d = is_wr_q ? S_WR_ADDR : S_RD_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD_FETCH: state_d = S_RD_PUT;
      S_RD_PUT: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_RD_FETCH;
        end
      end
      S_WR_ADDR: state_d = S_WR_CAP;
      S_WR_CAP: begin
        if (k_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          state_d = S_WR_ADDR;
        end
      end
      S_DONE: begin
        if (!held) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    active = state_d inside {S_RD_FETCH, S_RD_PUT, S_WR_ADDR, S_WR_CAP};
    for (int i = 0; i < NACK; i++) begin
      ack_d[i] = active && (drv_d == DRV_W'(i));
    end
    buff_addr_d = active ? k_d : '0;
    buff_wr_d   = (state_d == S_RD_PUT);
    mem_rd_d    = (state_d == S_RD_FETCH) && !mute_d;
    mem_wr_d    = (state_d == S_WR_CAP) && !mute_d;
    if (state_d == S_RD_FETCH || state_d == S_WR_CAP) begin
      mem_addr_d = base_d[IMG_AW-1:0] + IMG_AW'(k_d);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drv_q        <= '0;
      is_wr_q      <= 1'b0;
      base_q       <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      mute_q       <= 1'b0;
      sd_ack       <= '0;
      sd_buff_addr <= '0;
      sd_buff_wr   <= 1'b0;
      mem_addr     <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      xfer_err     <= 1'b0;
      img_mounted  <= '0;
      img_size     <= '0;
      img_readonly <= 1'b0;
    end else begin
      state_q      <= state_d;
      drv_q        <= drv_d;
      is_wr_q      <= is_wr_d;
      base_q       <= base_d;
      k_q          <= k_d;
      cnt_q        <= cnt_d;
      mute_q       <= mute_d;
      sd_ack       <= ack_d;
      sd_buff_addr <= buff_addr_d;
      sd_buff_wr   <= buff_wr_d;
      mem_addr     <= mem_addr_d;
      mem_rd       <= mem_rd_d;
      mem_wr       <= mem_wr_d;
      xfer_err     <= xfer_err || err_set;
      img_mounted  <= NACK'(mount_req);
      if (|mount_req) begin
        img_size     <= mount_size;
        img_readonly <= mount_ro;
      end
    end
  end

  // Data paths pass straight through: memory data lands in RD_PUT, loader data in WR_CAP.
  assign sd_buff_dout = (state_q == S_RD_PUT && !mute_q) ? mem_dout : 8'h00;
  assign mem_din      = (state_q == S_WR_CAP) ? din_sel : 8'h00;

endmodule

// File: tb/tb_sd_image_responder.sv
// Directed bench for sd_image_responder: two drives, a 4 KiB image, reads, writes,
// arbitration, range/read-only errors and mid-transfer reset.
module tb_sd_image_responder;

  localparam int unsigned ND = 2;
  localparam int unsigned AW = 12;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [ND-1:0] mount_req;
  logic [63:0]   mount_size;
  logic          mount_ro;
  logic [9:0]    img_mounted;
  logic [63:0]   img_size;
  logic          img_readonly;
  logic [ND*32-1:0] sd_lba;
  logic [9:0]    sd_rd;
  logic [9:0]    sd_wr;
  logic [9:0]    sd_ack;
  logic [8:0]    sd_buff_addr;
  logic [7:0]    sd_buff_dout;
  logic          sd_buff_wr;
  logic [ND*8-1:0] sd_buff_din;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_dout;
  logic          mem_wr;
  logic [7:0]    mem_din;
  logic          xfer_err;

  sd_image_responder #(.NUM_DRIVES(ND), .IMG_AW(AW), .ACK_DELAY(4)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .mount_req(mount_req), .mount_size(mount_size), .mount_ro(mount_ro),
    .img_mounted(img_mounted), .img_size(img_size), .img_readonly(img_readonly),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .xfer_err(xfer_err)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Image memory: synchronous read, data valid the cycle after mem_rd.
  logic [7:0] mem [4096];
  logic       mem_init;
  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int n = 0; n < 4096; n++) mem[n] <= 8'(n);
    end else begin
      if (mem_rd) mem_dout <= mem[mem_addr];
      if (mem_wr) mem[mem_addr] <= mem_din;
    end
  end

  // Loader: write data is ~addr, presented one cycle after the address.
  always @(posedge clk_sys) sd_buff_din <= {~sd_buff_addr[7:0], ~sd_buff_addr[7:0]};

  int         exp_mode = 0;
  int         strobes = 0, addr_errs = 0, data_errs = 0, rd_cnt = 0, wr_cnt = 0, overlap = 0;
  logic [8:0] next_addr = '0;

  function automatic logic [7:0] exp_byte(input logic [8:0] a);
    case (exp_mode)
      1:       return 8'h00;
      2:       return ~a[7:0];
      default: return a[7:0];
    endcase
  endfunction

  always @(negedge clk_sys) begin
    if (sd_buff_wr) begin
      if (sd_buff_addr !== next_addr) addr_errs++;
      if (sd_buff_dout !== exp_byte(sd_buff_addr)) data_errs++;
      strobes++;
      next_addr = next_addr + 9'd1;
    end
    if (sd_ack == '0) next_addr = '0;
    if (mem_rd) rd_cnt++;
    if (mem_wr) wr_cnt++;
    if (!$onehot0(sd_ack)) overlap++;
  end

  task automatic wait_ack(output int lat);
    lat = 0;
    while (sd_ack == '0 && lat < 100) begin
      @(negedge clk_sys);
      lat++;
    end
  endtask

  task automatic wait_drop(output int w);
    w = 0;
    while (sd_ack != '0 && w < 3000) begin
      @(negedge clk_sys);
      w++;
    end
  endtask

  // One full handshake; stale is sd_ack sampled while the request is still held after DONE.
  task automatic do_xfer(input int drv, input bit wr, input logic [31:0] lba,
                         output int lat, output int w, output logic [9:0] stale);
    sd_lba[drv*32 +: 32] = lba;
    if (wr) sd_wr[drv] = 1'b1;
    else    sd_rd[drv] = 1'b1;
    wait_ack(lat);
    wait_drop(w);
    repeat (8) @(negedge clk_sys);
    stale = sd_ack;
    sd_rd[drv] = 1'b0;
    sd_wr[drv] = 1'b0;
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic mount(input logic [63:0] size, input logic ro);
    mount_req  = ND'(1);
    mount_size = size;
    mount_ro   = ro;
    @(negedge clk_sys);
    mount_req  = '0;
  endtask

  initial begin
    int lat, w, errs, s_str, s_rd, s_wr;
    logic [9:0] stale;

    reset = 1'b1; mount_req = '0; mount_size = '0; mount_ro = 1'b0;
    sd_lba = '0; sd_rd = '0; sd_wr = '0; mem_init = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("rst_ack", sd_ack, 0);
    check("rst_mounted", img_mounted, 0);
    check("rst_size", img_size, 0);
    check("rst_bufwr", sd_buff_wr, 0);
    check("rst_memrd", mem_rd, 0);
    check("rst_memwr", mem_wr, 0);
    check("rst_err", xfer_err, 0);
    mem_init = 1'b0;
    reset = 1'b0;
    @(negedge clk_sys);

    mount(64'd4096, 1'b0);
    check("mount_pulse", img_mounted, 10'b1);
    check("mount_size", img_size, 4096);
    check("mount_ro", img_readonly, 0);
    @(negedge clk_sys);
    check("mount_pulse_end", img_mounted, 0);

    // Read LBA 2: bytes 1024..1535 of an n[7:0] image give k[7:0].
    exp_mode = 0; s_str = strobes; s_rd = rd_cnt;
    do_xfer(0, 1'b0, 32'd2, lat, w, stale);
    check("rd_latency", lat, 6);
    check("rd_ack_width", w, 1024);
    check("rd_no_reserve", stale, 0);
    check("rd_strobes", strobes - s_str, 512);
    check("rd_memrd", rd_cnt - s_rd, 512);
    check("rd_addr_errs", addr_errs, 0);
    check("rd_data_errs", data_errs, 0);
    check("rd_err", xfer_err, 0);

    // Write LBA 1 with ~k.
    s_str = strobes; s_wr = wr_cnt;
    do_xfer(0, 1'b1, 32'd1, lat, w, stale);
    check("wr_latency", lat, 6);
    check("wr_ack_width", w, 1024);
    check("wr_no_bufwr", strobes - s_str, 0);
    check("wr_memwr", wr_cnt - s_wr, 512);
    errs = 0;
    for (int k = 0; k < 512; k++) if (mem[512 + k] !== ~8'(k)) errs++;
    check("wr_mem_errs", errs, 0);
    check("wr_below", mem[511], 8'hFF);
    check("wr_above", mem[1024], 8'h00);
    check("wr_err", xfer_err, 0);

    exp_mode = 2; s_str = strobes;
    do_xfer(0, 1'b0, 32'd1, lat, w, stale);
    check("rb_strobes", strobes - s_str, 512);
    check("rb_data_errs", data_errs, 0);

    // Drive 0 write and drive 1 read raised together: drive 0 first.
    exp_mode = 0; s_str = strobes; s_wr = wr_cnt;
    sd_lba = {32'd4, 32'd3};
    sd_wr[0] = 1'b1; sd_rd[1] = 1'b1;
    wait_ack(lat);
    check("arb_first", sd_ack, 10'b01);
    wait_drop(w);
    check("arb_first_width", w, 1024);
    sd_wr[0] = 1'b0;
    wait_ack(lat);
    check("arb_second", sd_ack, 10'b10);
    wait_drop(w);
    check("arb_second_width", w, 1024);
    sd_rd[1] = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("arb_strobes", strobes - s_str, 512);
    check("arb_memwr", wr_cnt - s_wr, 512);
    check("arb_data_errs", data_errs, 0);
    errs = 0;
    for (int k = 0; k < 512; k++) if (mem[1536 + k] !== ~8'(k)) errs++;
    check("arb_mem_errs", errs, 0);
    check("arb_overlap", overlap, 0);

    // LBA 8 lies past a 4096-byte image.
    exp_mode = 1; s_str = strobes; s_rd = rd_cnt;
    do_xfer(0, 1'b0, 32'd8, lat, w, stale);
    check("oor_ack_width", w, 1024);
    check("oor_strobes", strobes - s_str, 512);
    check("oor_memrd", rd_cnt - s_rd, 0);
    check("oor_data_errs", data_errs, 0);
    check("oor_err", xfer_err, 1);

    // Reset around byte 100 of a read, then a fresh transfer with the request still held.
    exp_mode = 0; s_str = strobes;
    sd_lba[31:0] = 32'd2; sd_rd[0] = 1'b1;
    wait_ack(lat);
    lat = 0;
    while (strobes - s_str < 100 && lat < 1000) begin
      @(negedge clk_sys);
      lat++;
    end
    reset = 1'b1;
    #1;
    check("mid_rst_ack", sd_ack, 0);
    check("mid_rst_bufwr", sd_buff_wr, 0);
    check("mid_rst_addr", sd_buff_addr, 0);
    check("mid_rst_dout", sd_buff_dout, 0);
    check("mid_rst_memrd", mem_rd, 0);
    check("mid_rst_err", xfer_err, 0);
    check("mid_rst_size", img_size, 0);
    repeat (2) @(negedge clk_sys);
    s_str = strobes; s_rd = rd_cnt;
    reset = 1'b0;
    mount(64'd4096, 1'b0);
    wait_ack(lat);
    wait_drop(w);
    sd_rd[0] = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("post_rst_width", w, 1024);
    check("post_rst_strobes", strobes - s_str, 512);
    check("post_rst_memrd", rd_cnt - s_rd, 512);
    check("post_rst_addr_errs", addr_errs, 0);
    check("post_rst_data_errs", data_errs, 0);
    check("post_rst_err", xfer_err, 0);

    // Write to a read-only image: handshake completes, memory untouched.
    mount(64'd4096, 1'b1);
    check("ro_flag", img_readonly, 1);
    s_wr = wr_cnt;
    do_xfer(0, 1'b1, 32'd0, lat, w, stale);
    check("ro_ack_width", w, 1024);
    check("ro_memwr", wr_cnt - s_wr, 0);
    check("ro_err", xfer_err, 1);
    errs = 0;
    for (int k = 0; k < 512; k++) if (mem[k] !== 8'(k)) errs++;
    check("ro_mem_errs", errs, 0);
    check("final_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
